dkong_wav_rom_arb: RTL and testbench

Round-robin arbiter sharing the single wave-sample ROM read port between several sample players: walk/jump/foot, roar, and spare. It sits between the wave sound players, which each produce a 19-bit sample ROM address at 11025 Hz, and the external ROM/SDRAM controller, which has variable read latency. It serialises reads with one outstanding access and returns data to the granted player with a one-cycle acknowledge. A watchdog substitutes silence if the ROM never answers.

---
 rtl/dkong_wav_pkg.sv | 22 ++
 rtl/dkong_rr_arb.sv | 37 +++
 rtl/dkong_wav_rom_arb.sv | 118 +++++++++++
 tb/tb_dkong_wav_rom_arb.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/dkong_wav_pkg.sv
// Purpose: shared types and constants for the wave-sample ROM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dkong_wav_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } wav_state_t;

  localparam logic [7:0] WAV_SILENCE   = 8'h80;
  localparam int         WAV_N_REQ     = 3;
  localparam int         WAV_ADDR_W    = 19;

  // Slot index reached by stepping ofs places on from ptr, modulo n.
  function automatic int rr_slot(input int ptr, input int ofs, input int n);
    return (ptr + ofs) % n;
  endfunction

endpackage

// File: rtl/dkong_rr_arb.sv
// Purpose: combinational round-robin grant: first requester at or after rr_ptr.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; caller decides when the grant is taken.
// Ports: req (level requests), rr_ptr (search start), gnt (one-hot),
//        gnt_idx (binary index of gnt), gnt_vld (any request present).
module dkong_rr_arb
  import dkong_wav_pkg::*;
#(
  parameter int N_REQ = WAV_N_REQ,
  parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld
);

  logic [IDX_W-1:0] slot;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    slot    = '0;
    // Walk N_REQ slots starting at rr_ptr; the first hit wins.
    for (int i = 0; i < N_REQ; i++) begin
      slot = IDX_W'(rr_slot(int'(rr_ptr), i, N_REQ));
      if (!gnt_vld && req[slot]) begin
        gnt_vld   = 1'b1;
        gnt[slot] = 1'b1;
        gnt_idx   = slot;
      end
    end
  end

endmodule

// File: rtl/dkong_wav_rom_arb.sv
// Purpose: round-robin share of one wave-sample ROM read port, one read outstanding.
// Latency: request-to-ack = 2 + ROM latency (min 3 cycles); timeout ack TIMEOUT+2 after ISSUE.
// Backpressure: requests are level and wait in IDLE; a silent ROM is cut off by the watchdog.
// Ports: I_CLK/I_RST clock and sync reset; I_REQ/I_ADDR requester side;
//        O_ACK/O_DATA completion; O_ROM_AB/O_ROM_RD/I_ROM_DATA/I_ROM_VALID ROM side;
//        O_ERR sticky timeout flag.
module dkong_wav_rom_arb
  import dkong_wav_pkg::*;
#(
  parameter int N_REQ   = WAV_N_REQ,
  parameter int ADDR_W  = WAV_ADDR_W,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                    I_CLK,
  input  logic                    I_RST,
  input  logic [N_REQ-1:0]        I_REQ,
  input  logic [N_REQ*ADDR_W-1:0] I_ADDR,
  output logic [N_REQ-1:0]        O_ACK,
  output logic [DATA_W-1:0]       O_DATA,
  output logic [ADDR_W-1:0]       O_ROM_AB,
  output logic                    O_ROM_RD,
  input  logic [DATA_W-1:0]       I_ROM_DATA,
  input  logic                    I_ROM_VALID,
  output logic                    O_ERR
);

  localparam int               IDX_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [7:0]       TO_CNT  = 8'(TIMEOUT);
  localparam logic [DATA_W-1:0] SILENCE = DATA_W'(WAV_SILENCE);

  wav_state_t       state, state_nxt;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] g_idx;
  logic [N_REQ-1:0] g_oh;
  logic [7:0]       cnt;
  logic             timed_out;

  logic [N_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_vld;

  logic [ADDR_W-1:0] req_addr [N_REQ];

  for (genvar k = 0; k < N_REQ; k++) begin : g_addr
    assign req_addr[k] = I_ADDR[k*ADDR_W +: ADDR_W];
  end

  dkong_rr_arb #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req     (I_REQ),
    .rr_ptr  (rr_ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  assign timed_out = (cnt == TO_CNT);

  // State register.
  always_ff @(posedge I_CLK) begin
    if (I_RST) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state. ROM valid only counts in WAIT; a valid in ISSUE is dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arb_vld) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (I_ROM_VALID || timed_out) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant, address, data, watchdog and pointer registers.
  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      rr_ptr   <= '0;
      g_idx    <= '0;
      g_oh     <= '0;
      cnt      <= '0;
      O_ROM_AB <= '0;
      O_DATA   <= SILENCE;
      O_ERR    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (arb_vld) begin
          g_idx    <= arb_idx;
          g_oh     <= arb_gnt;
          O_ROM_AB <= req_addr[arb_idx];
        end
        ISSUE: cnt <= '0;
        WAIT: begin
          if (I_ROM_VALID) begin
            O_DATA <= I_ROM_DATA;
          end else if (timed_out) begin
            O_DATA <= SILENCE;
            O_ERR  <= 1'b1;
          end else if (cnt != 8'hFF) begin
            // Saturate rather than wrap so the watchdog can never be skipped.
            cnt <= cnt + 8'd1;
          end
        end
        DONE: rr_ptr <= IDX_W'(rr_slot(int'(g_idx), 1, N_REQ));
        default: ;
      endcase
    end
  end

  assign O_ROM_RD = (state == ISSUE);
  assign O_ACK    = (state == DONE) ? g_oh : '0;

endmodule

// File: tb/tb_dkong_wav_rom_arb.sv
module tb_dkong_wav_rom_arb;

  localparam int N_REQ   = 3;
  localparam int ADDR_W  = 19;
  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 10;

  localparam logic [18:0] A0 = 19'h13000;
  localparam logic [18:0] A1 = 19'h20001;
  localparam logic [18:0] A2 = 19'h7ABCD;

  logic                    I_CLK = 1'b0;
  logic                    I_RST;
  logic [N_REQ-1:0]        I_REQ;
  logic [N_REQ*ADDR_W-1:0] I_ADDR;
  logic [N_REQ-1:0]        O_ACK;
  logic [DATA_W-1:0]       O_DATA;
  logic [ADDR_W-1:0]       O_ROM_AB;
  logic                    O_ROM_RD;
  logic [DATA_W-1:0]       I_ROM_DATA;
  logic                    I_ROM_VALID;
  logic                    O_ERR;

  int n_chk  = 0;
  int n_pass = 0;

  dkong_wav_rom_arb #(
    .N_REQ   (N_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .I_CLK       (I_CLK),
    .I_RST       (I_RST),
    .I_REQ       (I_REQ),
    .I_ADDR      (I_ADDR),
    .O_ACK       (O_ACK),
    .O_DATA      (O_DATA),
    .O_ROM_AB    (O_ROM_AB),
    .O_ROM_RD    (O_ROM_RD),
    .I_ROM_DATA  (I_ROM_DATA),
    .I_ROM_VALID (I_ROM_VALID),
    .O_ERR       (O_ERR)
  );

  always #5 I_CLK = ~I_CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
  endtask

  // One transaction: wait for the read strobe, answer after lat cycles
  // (lat < 0: never answer), then check the ack pulse and returned data.
  task automatic serve(input string tag, input int lat, input logic [7:0] rom_byte,
                       input logic [2:0] exp_ack, input logic [18:0] exp_addr,
                       input bit drop, input bit spur);
    bit found;
    int n;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge I_CLK);
      if (O_ROM_RD) found = 1'b1;
    end
    chk({tag, "_rd"}, 32'(found), 32'd1);
    if (!found) return;
    chk({tag, "_ab"}, 32'(O_ROM_AB), 32'(exp_addr));
    if (spur) begin
      I_ROM_VALID = 1'b1;
      I_ROM_DATA  = 8'hEE;
    end
    if (lat < 0) begin
      n = 0;
      found = 1'b0;
      while (!found && n < 300) begin
        @(negedge I_CLK);
        I_ROM_VALID = 1'b0;
        n++;
        if (O_ACK != '0) found = 1'b1;
      end
      chk({tag, "_to_cycles"}, 32'(n), 32'(TIMEOUT + 2));
    end else begin
      for (int i = 0; i < lat; i++) begin
        @(negedge I_CLK);
        I_ROM_VALID = 1'b0;
        if (i == 0) chk({tag, "_rd_pulse"}, 32'(O_ROM_RD), 32'd0);
      end
      I_ROM_VALID = 1'b1;
      I_ROM_DATA  = rom_byte;
      @(negedge I_CLK);
      I_ROM_VALID = 1'b0;
    end
    chk({tag, "_ack"}, 32'(O_ACK), 32'(exp_ack));
    chk({tag, "_data"}, 32'(O_DATA), (lat < 0) ? 32'h80 : 32'(rom_byte));
    if (drop) I_REQ = I_REQ & ~exp_ack;
  endtask

  initial begin
    bit ack_seen;
    I_RST       = 1'b1;
    I_REQ       = '0;
    I_ADDR      = {A2, A1, A0};
    I_ROM_DATA  = '0;
    I_ROM_VALID = 1'b0;
    repeat (2) @(negedge I_CLK);
    chk("rst_ack",  32'(O_ACK),    32'd0);
    chk("rst_rd",   32'(O_ROM_RD), 32'd0);
    chk("rst_ab",   32'(O_ROM_AB), 32'd0);
    chk("rst_data", 32'(O_DATA),   32'h80);
    chk("rst_err",  32'(O_ERR),    32'd0);
    I_RST = 1'b0;

    // Fairness: all three held, order 0,1,2,0,1,2.
    I_REQ = 3'b111;
    serve("fair0", 1, 8'h10, 3'b001, A0, 1'b0, 1'b0);
    serve("fair1", 1, 8'h11, 3'b010, A1, 1'b0, 1'b0);
    serve("fair2", 1, 8'h12, 3'b100, A2, 1'b0, 1'b0);
    serve("fair3", 1, 8'h13, 3'b001, A0, 1'b0, 1'b0);
    serve("fair4", 1, 8'h14, 3'b010, A1, 1'b0, 1'b0);
    serve("fair5", 1, 8'h15, 3'b100, A2, 1'b0, 1'b0);
    I_REQ = '0;

    // Single request, ROM latency 2 (rr_ptr is back at 0).
    @(negedge I_CLK);
    I_REQ = 3'b001;
    serve("single", 2, 8'h5A, 3'b001, A0, 1'b1, 1'b0);

    // Serve ch1 alone so rr_ptr becomes 2, then 011 must wrap to ch0 first.
    I_REQ = 3'b010;
    serve("wrap_pre", 1, 8'h21, 3'b010, A1, 1'b1, 1'b0);
    I_REQ = 3'b011;
    serve("wrap_a", 1, 8'h22, 3'b001, A0, 1'b1, 1'b0);
    serve("wrap_b", 1, 8'h23, 3'b010, A1, 1'b1, 1'b0);

    // Timeout on ch2, then a good read must leave O_ERR set.
    I_REQ = 3'b100;
    serve("tmo", -1, 8'h00, 3'b100, A2, 1'b1, 1'b0);
    chk("tmo_err", 32'(O_ERR), 32'd1);
    I_REQ = 3'b001;
    serve("post_tmo", 1, 8'h3C, 3'b001, A0, 1'b1, 1'b0);
    chk("err_sticky", 32'(O_ERR), 32'd1);

    // Spurious valid in IDLE with nothing requested.
    @(negedge I_CLK);
    I_ROM_VALID = 1'b1;
    I_ROM_DATA  = 8'h55;
    @(negedge I_CLK);
    I_ROM_VALID = 1'b0;
    chk("spur_idle_ack",  32'(O_ACK),  32'd0);
    chk("spur_idle_data", 32'(O_DATA), 32'h3C);
    // Spurious valid in the ISSUE cycle; real answer arrives later.
    I_REQ = 3'b100;
    serve("spur_issue", 3, 8'h77, 3'b100, A2, 1'b1, 1'b1);

    // One more read so rr_ptr sits at 1 before the reset test.
    I_REQ = 3'b001;
    serve("pre_rst", 1, 8'h44, 3'b001, A0, 1'b1, 1'b0);

    // Reset in the middle of WAIT.
    I_REQ = 3'b010;
    ack_seen = 1'b0;
    for (int i = 0; i < 20 && !O_ROM_RD; i++) @(negedge I_CLK);
    @(negedge I_CLK);
    I_RST = 1'b1;
    I_REQ = '0;
    @(negedge I_CLK);
    I_RST = 1'b0;
    chk("mid_rst_ack",  32'(O_ACK),    32'd0);
    chk("mid_rst_rd",   32'(O_ROM_RD), 32'd0);
    chk("mid_rst_ab",   32'(O_ROM_AB), 32'd0);
    chk("mid_rst_data", 32'(O_DATA),   32'h80);
    chk("mid_rst_err",  32'(O_ERR),    32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge I_CLK);
      if (O_ACK != '0) ack_seen = 1'b1;
    end
    chk("mid_rst_no_ack", 32'(ack_seen), 32'd0);
    // rr_ptr must be 0: with 101, ch0 comes before ch2.
    I_REQ = 3'b101;
    serve("after_rst_a", 1, 8'h61, 3'b001, A0, 1'b1, 1'b0);
    serve("after_rst_b", 2, 8'h62, 3'b100, A2, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
